// File: rtl/binario_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding,
// add-3 correction constants and the iteration counter width.
package binario_bcd_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    FIM     = 2'd2
  } estado_e;

  localparam logic [3:0] LIMIAR_AJUSTE = 4'd5;
  localparam logic [3:0] SOMA_AJUSTE   = 4'd3;

  // Counter must hold the value LARGURA itself, hence the +1.
  function automatic int largura_contador(input int largura);
    return $clog2(largura + 1);
  endfunction

endpackage

// File: rtl/ajuste_digito.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module ajuste_digito
  import binario_bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= LIMIAR_AJUSTE) ? d_i + SOMA_AJUSTE : d_i;

endmodule

// File: rtl/binario_para_bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock. Result and
// overflow flag stay stable between conversions and update with pronto.
module binario_para_bcd
  import binario_bcd_pkg::*;
#(
  parameter int LARGURA = 16,
  parameter int DIGITOS = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  input  logic [LARGURA-1:0]     binario,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic                   estouro
);

  localparam int CW = largura_contador(LARGURA);
  localparam int SW = 4 * DIGITOS;

  estado_e                estado_q, estado_d;
  logic [LARGURA-1:0]     desl_q, desl_d;
  logic [SW-1:0]          rasc_q, rasc_d;
  logic                   est_rasc_q, est_rasc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          bcd_q, bcd_d;
  logic                   estouro_q, estouro_d;
  logic                   pronto_q, pronto_d;

  logic [DIGITOS-1:0][3:0] ajust;
  logic [SW+LARGURA-1:0]   conj;

  for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
    ajuste_digito u_ajuste (
      .d_i (rasc_q[4*g +: 4]),
      .d_o (ajust[g])
    );
  end

  // The MSB of the corrected top digit is lost by the shift; it is the
  // overflow indicator and is captured separately below.
  assign conj = {ajust, desl_q} << 1;

  always_comb begin
    estado_d   = estado_q;
    desl_d     = desl_q;
    rasc_d     = rasc_q;
    est_rasc_d = est_rasc_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    estouro_d  = estouro_q;
    pronto_d   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          desl_d     = binario;
          rasc_d     = '0;
          est_rasc_d = 1'b0;
          cnt_d      = CW'(LARGURA);
          estado_d   = DESLOCA;
        end
      end
      DESLOCA: begin
        rasc_d     = conj[SW+LARGURA-1:LARGURA];
        desl_d     = conj[LARGURA-1:0];
        est_rasc_d = est_rasc_q | ajust[DIGITOS-1][3];
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) estado_d = FIM;
      end
      FIM: begin
        bcd_d     = rasc_q;
        estouro_d = est_rasc_q;
        pronto_d  = 1'b1;
        estado_d  = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      desl_q     <= '0;
      rasc_q     <= '0;
      est_rasc_q <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      estouro_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      desl_q     <= desl_d;
      rasc_q     <= rasc_d;
      est_rasc_q <= est_rasc_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      estouro_q  <= estouro_d;
      pronto_q   <= pronto_d;
    end
  end

  assign ocupado = (estado_q != OCIOSO);
  assign pronto  = pronto_q;
  assign bcd     = bcd_q;
  assign estouro = estouro_q;

endmodule

// File: tb/tb_binario_para_bcd.sv
// Directed and swept checks of binario_para_bcd in two configurations.
module tb_binario_para_bcd;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ini_a, ocup_a, pron_a, est_a;
  logic [15:0] bin_a;
  logic [19:0] bcd_a;
  logic        ini_b, ocup_b, pron_b, est_b;
  logic [9:0]  bin_b;
  logic [11:0] bcd_b;

  binario_para_bcd #(.LARGURA(16), .DIGITOS(5)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .inicio(ini_a), .binario(bin_a),
    .ocupado(ocup_a), .pronto(pron_a), .bcd(bcd_a), .estouro(est_a)
  );

  binario_para_bcd #(.LARGURA(10), .DIGITOS(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .inicio(ini_b), .binario(bin_b),
    .ocupado(ocup_b), .pronto(pron_b), .bcd(bcd_b), .estouro(est_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_bcd(input int unsigned v, input int nd);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic run_a(input string tag, input logic [15:0] v,
                       input logic [19:0] exp_bcd, input logic exp_ov);
    logic [19:0] antes;
    int occ, k;
    bit mudou;
    @(posedge clk); #1;
    ini_a = 1'b1; bin_a = v; antes = bcd_a;
    @(posedge clk); #1;
    ini_a = 1'b0; bin_a = 16'($urandom);
    occ = ocup_a ? 1 : 0; mudou = 0; k = 0;
    while (!pron_a && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (!pron_a && ocup_a) occ++;
      if (!pron_a && bcd_a !== antes) mudou = 1;
    end
    chk({tag, "_lat"}, k, 17);
    chk({tag, "_ocup"}, occ, 17);
    chk({tag, "_held"}, mudou, 0);
    chk({tag, "_bcd"}, bcd_a, exp_bcd);
    chk({tag, "_est"}, est_a, exp_ov);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, pron_a, 0);
  endtask

  task automatic run_b(input string tag, input logic [9:0] v,
                       input logic [11:0] exp_bcd, input logic exp_ov);
    int k;
    @(posedge clk); #1;
    ini_b = 1'b1; bin_b = v;
    @(posedge clk); #1;
    ini_b = 1'b0; bin_b = '0;
    k = 0;
    while (!pron_b && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_lat"}, k, 11);
    chk({tag, "_bcd"}, bcd_b, exp_bcd);
    chk({tag, "_est"}, est_b, exp_ov);
    @(posedge clk); #1;
  endtask

  logic [15:0] vals [0:19999];
  int cyc, np, lastp, k, nprt;
  bit mudou;

  initial begin
    rst_n = 1'b0;
    ini_a = 1'b0; bin_a = '0;
    ini_b = 1'b0; bin_b = '0;
    #12;
    chk("rst_ocup", ocup_a, 0);
    chk("rst_pronto", pron_a, 0);
    chk("rst_bcd", bcd_a, 0);
    chk("rst_est", est_a, 0);
    @(negedge clk) rst_n = 1'b1;

    run_a("zero", 16'd0,     20'h00000, 1'b0);
    run_a("n1234", 16'd1234, 20'h01234, 1'b0);
    run_a("max",  16'd65535, 20'h65535, 1'b0);

    // inicio during a conversion must be ignored
    @(posedge clk); #1;
    ini_a = 1'b1; bin_a = 16'd1234;
    @(posedge clk); #1;
    ini_a = 1'b0; bin_a = '0;
    k = 0; nprt = 0; mudou = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (pron_a) begin nprt++; k = c; end
      if (nprt == 0 && bcd_a !== 20'h65535) mudou = 1;
      if (c == 5) begin ini_a = 1'b1; bin_a = 16'd9999; end
      else ini_a = 1'b0;
    end
    chk("ign_npronto", nprt, 1);
    chk("ign_lat", k, 17);
    chk("ign_held", mudou, 0);
    chk("ign_bcd", bcd_a, 20'h01234);

    // asynchronous reset in the 5th shift cycle
    @(posedge clk); #1;
    ini_a = 1'b1; bin_a = 16'd65535;
    @(posedge clk); #1;
    ini_a = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("arst_ocup", ocup_a, 0);
    chk("arst_pronto", pron_a, 0);
    chk("arst_bcd", bcd_a, 0);
    chk("arst_est", est_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nprt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (pron_a) nprt++;
    end
    chk("arst_nopronto", nprt, 0);
    run_a("n42", 16'd42, 20'h00042, 1'b0);

    run_b("b1023", 10'd1023, 12'h023, 1'b1);
    run_b("b999",  10'd999,  12'h999, 1'b0);

    // back-to-back with inicio held and binario changing every cycle
    @(posedge clk); #1;
    cyc = 0; np = 0; lastp = -1;
    ini_a = 1'b1; bin_a = 16'($urandom_range(0, 65535));
    vals[0] = bin_a;
    while (np < 1000 && cyc < 19000) begin
      @(posedge clk); #1;
      cyc++;
      if (pron_a) begin
        if (cyc >= 18) begin
          chk("sweep_bcd", bcd_a, ref_bcd(vals[cyc-18], 5));
          chk("sweep_est", est_a, 0);
        end
        if (lastp >= 0) chk("sweep_gap", cyc - lastp, 18);
        lastp = cyc;
        np++;
      end
      bin_a = 16'($urandom_range(0, 65535));
      vals[cyc] = bin_a;
    end
    ini_a = 1'b0;
    chk("sweep_n", np, 1000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/binario_para_bcd.md
Name: binario_para_bcd

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
Sits directly upstream of the BCD-to-seven-segment decoders: each 4-bit nibble of bcd drives one decoder instance.
Accepts a binary value through a start/busy/done handshake and holds the last result stable between conversions.

Parameters:
LARGURA, 16, width of the binary input in bits (>=1)
DIGITOS, 5, number of BCD digits produced (>=1); result is modulo 10^DIGITOS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
inicio  input  1  start request; sampled only in OCIOSO
binario  input  LARGURA  value to convert; captured on the accepted inicio cycle
ocupado  output  1  high while a conversion is in progress (DESLOCA, FIM)
pronto  output  1  one-cycle pulse: bcd/estouro updated this cycle
bcd  output  4*DIGITOS  packed BCD result; digit k at bits [4k+3:4k], digit 0 = units
estouro  output  1  result did not fit in DIGITOS digits; valid with pronto, held until next pronto

Behaviour:
- Reset (rst_n low, async): state=OCIOSO, ocupado=0, pronto=0, bcd=0, estouro=0, scratch/shift/counter registers=0. Reset mid-conversion aborts it; no pronto follows.
- States: OCIOSO, DESLOCA, FIM.
- OCIOSO: ocupado=0. If inicio=1: capture binario into shift register, clear BCD scratch and overflow scratch, load counter=LARGURA, go to DESLOCA.
- DESLOCA: ocupado=1. Each cycle:
  - Every scratch digit >=5 gets +3 (4-bit, no carry between digits).
  - Then {scratch, shift} shifts left one bit.
  - Bit shifted out of the top digit is ORed into the overflow scratch.
  - Counter decrements; on the cycle it reaches 0 (LARGURA shifts done), go to FIM.
- FIM: ocupado=1. Copy scratch to bcd, overflow scratch to estouro, pronto=1 for this cycle only. Go to OCIOSO.
- Latency: inicio accepted at edge N -> pronto high in cycle N+LARGURA+1. Next inicio is accepted the cycle after pronto. Throughput: one conversion per LARGURA+2 cycles.
- inicio while ocupado=1 is ignored. Not queued, and binario is not recaptured.
- binario may change freely after the accepting edge.
- bcd and estouro change only in FIM; they hold their value otherwise, including during a new conversion.
- Width rule: bcd digits are always 0..9. If the input exceeds 10^DIGITOS-1, bcd = input mod 10^DIGITOS and estouro=1.
- Input 0 converts in full latency to bcd=0, estouro=0. There is no early-exit path.

Decomposition:
- Shared package binario_bcd_pkg:
  - State enum {OCIOSO, DESLOCA, FIM}.
  - Constants LIMIAR_AJUSTE=4'd5 and SOMA_AJUSTE=4'd3.
  - Function for the counter width, $clog2(LARGURA+1).
- Sub-module ajuste_digito (combinational): 4-bit in, 4-bit out, +3 if >=5. Instantiated DIGITOS times via generate.

Test Plan:
- Defaults; reset, then inicio with binario=16'd0 -> ocupado high for 17 cycles; pronto 17 cycles after the accepting edge; bcd=20'h00000, estouro=0.
- binario=16'd1234 -> bcd=20'h01234, estouro=0. binario=16'd65535 -> bcd=20'h65535, estouro=0, latency exactly 17.
- Start 1234; mid-conversion pulse inicio with binario=9999 -> ignored; result 20'h01234 with one pronto. Previous bcd held until that pronto.
- LARGURA=10, DIGITOS=3, binario=1023 -> bcd=12'h023, estouro=1. Then 999 -> bcd=12'h999, estouro=0.
- Drop rst_n at 5th DESLOCA cycle of a 65535 conversion -> all outputs 0 immediately (async), no pronto. After release, a new conversion of 42 -> bcd=20'h00042.
- Back-to-back: hold inicio=1 continuously with changing binario -> conversions accepted every 18 cycles, each bcd matching the value present at its accepting edge. Random 1000-value sweep checked against a reference model.
